// File: rtl/signed_divider_if.sv
// Request/response bundle for signed_divider: the master presents operands and start,
// and the divider returns its status and the held results.
interface signed_divider_if #(
    parameter int N = 32
);
    logic         start;
    logic         signed_op;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/signed_divider.sv
// Sequential N-bit signed/unsigned divider: one restoring shift-subtract step per cycle,
// sign handling done on magnitudes before and after the iteration loop.
module signed_divider #(
    parameter int N = 32
) (
    input  logic            clk,
    input  logic            reset,
    signed_divider_if.slave bus
);
    localparam int            CW   = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [N-1:0]  dvnd;
    logic [N-1:0]  dvsr;
    logic [N-1:0]  quo_acc;
    logic [N:0]    part_rem;
    logic [N+1:0]  trial;
    logic          sop, neg_q, neg_r, dbz;
    logic          busy_r, done_r, dbz_r;
    logic [N-1:0]  quo_r, rem_r;

    function automatic logic [N-1:0] negate(input logic [N-1:0] v);
        return ~v + N'(1);
    endfunction

    // Shift the next dividend bit into the partial remainder and trial-subtract;
    // the top bit of trial is the borrow that decides whether to restore.
    assign trial = {part_rem, quo_acc[N-1]} - {2'b00, dvsr};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: every register, datapath included, is cleared so an aborted
            // operation leaves nothing behind for the next start to trip over.
            state    <= IDLE;
            count    <= '0;
            dvnd     <= '0;
            dvsr     <= '0;
            quo_acc  <= '0;
            part_rem <= '0;
            sop      <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dbz      <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
            quo_r    <= '0;
            rem_r    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the
            // pre-edge register values regardless of statement order.
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvnd   <= bus.dividend;
                        dvsr   <= bus.divisor;
                        sop    <= bus.signed_op;
                        busy_r <= 1'b1;
                        state  <= PREP;
                    end
                end
                PREP: begin
                    quo_acc  <= (sop && dvnd[N-1]) ? negate(dvnd) : dvnd;
                    dvsr     <= (sop && dvsr[N-1]) ? negate(dvsr) : dvsr;
                    part_rem <= '0;
                    count    <= '0;
                    neg_q    <= sop & (dvnd[N-1] ^ dvsr[N-1]);
                    neg_r    <= sop & dvnd[N-1];
                    dbz      <= (dvsr == '0);
                    state    <= (dvsr == '0) ? FIX : ITER;
                end
                ITER: begin
                    if (trial[N+1]) begin
                        part_rem <= {part_rem[N-1:0], quo_acc[N-1]};
                        quo_acc  <= {quo_acc[N-2:0], 1'b0};
                    end else begin
                        part_rem <= trial[N:0];
                        quo_acc  <= {quo_acc[N-2:0], 1'b1};
                    end
                    count <= count + CW'(1);
                    if (count == LAST) state <= FIX;
                end
                FIX: begin
                    // Results land only here, so the outputs never show partial values.
                    if (dbz) begin
                        quo_r <= '1;
                        rem_r <= dvnd;
                    end else begin
                        quo_r <= neg_q ? negate(quo_acc) : quo_acc;
                        rem_r <= neg_r ? negate(part_rem[N-1:0]) : part_rem[N-1:0];
                    end
                    dbz_r  <= dbz;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider: directed corner cases, busy/reset behaviour and
// random operands, all compared against a 64-bit arithmetic reference model.
module tb_signed_divider;
    localparam int N = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    signed_divider_if #(.N(N)) bus ();

    signed_divider #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required finish within 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit division, truncating toward zero with the remainder
    // taking the dividend's sign; a zero divisor returns all ones and the dividend.
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                                  output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = N'(sa / sb);
            r  = N'(sa % sb);
            z  = 1'b0;
        end else begin
            ua = {32'd0, a};
            ub = {32'd0, b};
            q  = N'(ua / ub);
            r  = N'(ua % ub);
            z  = 1'b0;
        end
    endfunction

    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.signed_op = s;
        bus.start     = 1'b1;
    endtask

    // Called with start already high so that the coming rising edge is the start edge;
    // returns at the falling edge where done is seen. poke_at > 0 pulses a foreign start.
    task automatic collect(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                           input string tag, input int poke_at);
        logic [N-1:0] eq, er, prev_q, prev_r;
        logic         ez;
        logic         held_ok;
        int           k;
        int           lat;
        model(a, b, s, eq, er, ez);
        lat     = (b == '0) ? 3 : N + 3;
        prev_q  = bus.quotient;
        prev_r  = bus.remainder;
        held_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 1;
        check({tag, ".busy"}, N'(bus.busy), N'(1));
        while (bus.done !== 1'b1 && k < 4 * N) begin
            if (k == poke_at) drive(32'd1000, 32'd3, ~s);
            @(negedge clk);
            bus.start = 1'b0;
            k++;
            if (bus.done !== 1'b1 && (bus.quotient !== prev_q || bus.remainder !== prev_r))
                held_ok = 1'b0;
        end
        check({tag, ".latency"}, N'(k), N'(lat));
        check({tag, ".done"}, N'(bus.done), N'(1));
        check({tag, ".quotient"}, bus.quotient, eq);
        check({tag, ".remainder"}, bus.remainder, er);
        check({tag, ".div_by_zero"}, N'(bus.div_by_zero), N'(ez));
        check({tag, ".outputs_held"}, N'(held_ok), N'(1));
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          input string tag, input int poke_at);
        logic [N-1:0] eq, er;
        logic         ez;
        model(a, b, s, eq, er, ez);
        @(negedge clk);
        drive(a, b, s);
        collect(a, b, s, tag, poke_at);
        @(negedge clk);
        check({tag, ".done_one_cycle"}, N'(bus.done), N'(0));
        check({tag, ".busy_after"}, N'(bus.busy), N'(0));
        check({tag, ".quotient_kept"}, bus.quotient, eq);
    endtask

    initial begin
        logic done_seen;

        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b0;
        #1;
        check("reset.busy", N'(bus.busy), N'(0));
        check("reset.done", N'(bus.done), N'(0));
        check("reset.quotient", bus.quotient, '0);
        check("reset.remainder", bus.remainder, '0);
        check("reset.div_by_zero", N'(bus.div_by_zero), N'(0));

        // Start presented on the very first edge with reset released.
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(32'd100, 32'd7, 1'b0);
        collect(32'd100, 32'd7, 1'b0, "first_after_reset", 0);

        run_op(32'd100, 32'd7, 1'b0, "unsigned_100_7", 0);
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, "signed_neg100_7", 0);
        run_op(32'd100, 32'hFFFF_FFF9, 1'b1, "signed_100_neg7", 0);
        run_op(32'd5, 32'd0, 1'b0, "div0_unsigned", 0);
        run_op(32'd5, 32'd0, 1'b1, "div0_signed", 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "signed_overflow", 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "unsigned_big", 0);

        // Foreign start while busy: first result stands and no second done follows.
        run_op(32'd100, 32'd7, 1'b0, "start_while_busy", 5);
        done_seen = 1'b0;
        repeat (N + 8) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen = 1'b1;
        end
        check("start_while_busy.no_second_done", N'(done_seen), N'(0));

        // Start raised during the done cycle is taken in the following IDLE cycle.
        @(negedge clk);
        drive(32'd77, 32'd5, 1'b0);
        collect(32'd77, 32'd5, 1'b0, "chain_first", 0);
        drive(32'hFFFF_FFEC, 32'd6, 1'b1);
        @(negedge clk);
        check("chain.idle_gap_done", N'(bus.done), N'(0));
        check("chain.idle_gap_busy", N'(bus.busy), N'(0));
        collect(32'hFFFF_FFEC, 32'd6, 1'b1, "chain_second", 0);

        // Reset pulsed mid-iteration aborts the operation for good.
        @(negedge clk);
        drive(32'd100, 32'd7, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort.busy", N'(bus.busy), N'(0));
        check("abort.done", N'(bus.done), N'(0));
        check("abort.quotient", bus.quotient, '0);
        check("abort.remainder", bus.remainder, '0);
        check("abort.div_by_zero", N'(bus.div_by_zero), N'(0));
        @(negedge clk);
        reset = 1'b1;
        done_seen = 1'b0;
        repeat (N + 8) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
        end
        check("abort.no_resume", N'(done_seen), N'(0));
        run_op(32'd9, 32'd3, 1'b0, "after_abort_9_3", 0);

        for (int i = 0; i < 24; i++) begin
            logic [N-1:0] a, b;
            logic         s;
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = N'($urandom_range(1, 15));
                3:       b = -N'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(a, b, s, $sformatf("rand%0d", i), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/signed_divider.md
SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 SHALL have parameter N, default WORD_WIDTH (32), giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 SHALL have port signed_op, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have port dividend, input, N bits: numerator, captured with start.
REQ-007 SHALL have port divisor, input, N bits: denominator, captured with start.
REQ-008 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when the results become valid.
REQ-010 SHALL have port quotient, output, N bits: result, held stable until the next accepted start.
REQ-011 SHALL have port remainder, output, N bits: result, held stable until the next accepted start.
REQ-012 SHALL have port div_by_zero, output, 1 bit: flag valid with done, held with the results.

Function
REQ-013 SHALL implement FSM states IDLE, PREP, ITER, FIX and DONE.
REQ-014 SHALL, in IDLE with start=1, capture the operands and signed_op and enter PREP; start=0 stays in IDLE.
REQ-015 SHALL, in PREP, replace each operand that is negative under signed_op=1 by its two's-complement magnitude (invert plus 1; width N; carry-out discarded) and record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
REQ-016 SHALL, in PREP with divisor=0, skip ITER and go to FIX with div_by_zero set.
REQ-017 SHALL, in ITER, perform exactly N restoring shift-subtract iterations, one per cycle, with an internal counter of ceil(log2 N)+1 bits and an (N+1)-bit partial remainder.
REQ-018 SHALL, in FIX, negate the quotient if neg_q and the remainder if neg_r (two's complement, width N), then go to DONE.
REQ-019 SHALL, in FIX for a zero divisor, set quotient = all ones and remainder = the original captured dividend, regardless of signed_op.
REQ-020 SHALL, for signed overflow (dividend = 1 followed by N-1 zeros, divisor = all ones), produce quotient = dividend and remainder = 0 with no special path, since the N-bit negation wraps naturally.
REQ-021 SHALL, in DONE, assert done for exactly one cycle, drive quotient, remainder and div_by_zero, and return to IDLE.
REQ-022 SHALL have a latency of N+3 cycles from the start-sampling edge to done for a nonzero divisor (PREP 1, ITER N, FIX 1, DONE 1), and 3 cycles for a zero divisor.
REQ-023 SHALL ignore start while busy=1; operands SHALL NOT be re-captured.
REQ-024 SHALL accept a start asserted in the cycle done is high on the next cycle, in IDLE; back-to-back operations are separated by one IDLE cycle.
REQ-025 SHALL keep outputs free of intermediate values: quotient and remainder SHALL change only on entry to DONE or on reset.

Reset
REQ-026 SHALL, on reset low, immediately and asynchronously force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear the counter and all internal registers.
REQ-027 SHALL, on reset asserted mid-operation, abort the operation with no done pulse; the operation SHALL NOT resume after reset deasserts.
REQ-028 SHALL, on the first rising clk edge with reset high, be able to accept start.

Verification
REQ-029 SHALL cover an unsigned divide: dividend=100, divisor=7, signed_op=0 -> quotient=14, remainder=2, div_by_zero=0, done exactly 35 cycles after the start edge (N=32).
REQ-030 SHALL cover a signed divide with a negative dividend: dividend=FFFFFF9C (-100), divisor=7, signed_op=1 -> quotient=FFFFFFF2, remainder=FFFFFFFE.
REQ-031 SHALL cover divide by zero: dividend=5, divisor=0, either mode -> quotient=FFFFFFFF, remainder=5, div_by_zero=1, done 3 cycles after start.
REQ-032 SHALL cover signed overflow: dividend=80000000, divisor=FFFFFFFF, signed_op=1 -> quotient=80000000, remainder=0, div_by_zero=0.
REQ-033 SHALL cover a start pulse while busy, with different operands, 5 cycles into 100/7 -> the first result is unaffected and no second done appears.
REQ-034 SHALL cover reset pulsed low for 1 cycle at iteration 10 -> all outputs 0 immediately, no done; a new start of 9/3 then yields quotient=3, remainder=0.
